// File: rtl/apb_mm_csr.sv
// APB control/status front end of the matrix multiplier: start/dimension/status CSRs plus a
// DATA window bridged onto the core's req/gnt + rvalid operand/result memory port.
module apb_mm_csr #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DIM_WIDTH      = 8
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      mm_start,
  output logic [DIM_WIDTH-1:0]      mm_dim_m,
  output logic [DIM_WIDTH-1:0]      mm_dim_n,
  output logic [DIM_WIDTH-1:0]      mm_dim_k,
  input  logic                      mm_busy,
  input  logic                      mm_done
);

  localparam logic [4:0] OffCtrl   = 5'h00;
  localparam logic [4:0] OffStatus = 5'h04;
  localparam logic [4:0] OffDim    = 5'h08;
  localparam logic [4:0] OffAddr   = 5'h0C;
  localparam logic [4:0] OffData   = 5'h10;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StAck} state_e;

  state_e                    state_q;
  logic                      mem_req_q, mem_we_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, data_addr_q;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, rdata_q;
  logic [DIM_WIDTH-1:0]      dim_m_q, dim_n_q, dim_k_q;
  logic                      done_q, start_q;

  logic [4:0] offset;
  logic       csr_acc, data_acc, csr_wr;
  logic       unused_paddr;

  assign offset       = paddr[4:0];
  assign unused_paddr = ^paddr[ADDR_WIDTH-1:5];
  assign csr_acc      = (state_q == StIdle) && psel && penable && (offset != OffData);
  assign data_acc     = (state_q == StIdle) && psel && penable && (offset == OffData);
  assign csr_wr       = csr_acc && pwrite;

  // Memory bridge FSM. Once a DATA transfer is accepted it always runs to the ACK cycle,
  // even if the master abandons the APB transfer.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      data_addr_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (data_acc) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= pwrite;
            mem_wdata_q <= pwdata;
            mem_addr_q  <= data_addr_q;
            state_q     <= StReq;
          end else if (csr_wr && offset == OffAddr) begin
            data_addr_q <= pwdata[MEM_ADDR_WIDTH-1:0];
          end
        end
        StReq: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? StAck : StResp;
          end
        end
        StResp: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state_q <= StAck;
          end
        end
        StAck: begin
          data_addr_q <= data_addr_q + MEM_ADDR_WIDTH'(1);
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      dim_m_q <= '0;
      dim_n_q <= '0;
      dim_k_q <= '0;
    end else begin
      start_q <= csr_wr && (offset == OffCtrl) && pwdata[0] && !mm_busy;
      // A completion arriving with the clearing write must not be lost.
      done_q  <= mm_done | (done_q & ~(csr_wr && (offset == OffStatus) && pwdata[1]));
      if (csr_wr && (offset == OffDim) && !mm_busy) begin
        {dim_k_q, dim_n_q, dim_m_q} <= pwdata[3*DIM_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    prdata = '0;
    case (state_q)
      StIdle: begin
        if (psel) begin
          case (offset)
            OffStatus: prdata = DATA_WIDTH'({done_q, mm_busy});
            OffDim:    prdata = DATA_WIDTH'({dim_k_q, dim_n_q, dim_m_q});
            OffAddr:   prdata = DATA_WIDTH'(data_addr_q);
            default:   prdata = '0;
          endcase
        end
      end
      StAck:   prdata = rdata_q;
      default: prdata = '0;
    endcase
  end

  assign pready    = csr_acc || (state_q == StAck);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mm_start  = start_q;
  assign mm_dim_m  = dim_m_q;
  assign mm_dim_n  = dim_n_q;
  assign mm_dim_k  = dim_k_q;

endmodule

// File: tb/tb_apb_mm_csr.sv
// Bench for apb_mm_csr: CSR vector table, hand-written corner sequences and randomized DATA
// traffic against an array-based memory model with a latency formula.
module tb_apb_mm_csr;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mm_start;
  logic [7:0]  mm_dim_m, mm_dim_n, mm_dim_k;
  logic        mm_busy, mm_done;

  apb_mm_csr dut (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mm_start(mm_start), .mm_dim_m(mm_dim_m), .mm_dim_n(mm_dim_n), .mm_dim_k(mm_dim_k),
    .mm_busy(mm_busy), .mm_done(mm_done)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: gnt after gnt_dly waiting cycles, rvalid rv_dly cycles after gnt.
  logic [31:0] memarr [1024];
  int          gnt_dly = 0, rv_dly = 1;
  int          req_cnt = 0, req_hold = 0, rv_cnt = 0, access_cnt = 0;
  bit          rv_pend = 0, unstable = 0;
  logic [31:0] rv_data, cap_wdata;
  logic [9:0]  cap_addr;
  logic        cap_we;

  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int i = 0; i < 1024; i++) memarr[i] = 0;
    forever begin
      @(negedge pclk);
      mem_gnt = 0; mem_rvalid = 0;
      if (!preset_n) begin
        req_cnt = 0; rv_pend = 0;
      end else begin
        if (rv_pend) begin
          if (rv_cnt == 0) begin
            mem_rvalid = 1; mem_rdata = rv_data; rv_pend = 0;
          end else rv_cnt--;
        end
        if (mem_req) begin
          if (req_cnt == 0) begin
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we; unstable = 0;
          end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we)
            unstable = 1;
          if (req_cnt == gnt_dly) begin
            mem_gnt = 1; req_hold = req_cnt + 1; req_cnt = 0; access_cnt++;
            if (mem_we) memarr[mem_addr] = mem_wdata;
            else begin
              rv_pend = 1; rv_cnt = rv_dly - 1; rv_data = memarr[mem_addr];
            end
          end else req_cnt++;
        end
      end
    end
  end

  // One APB transfer; cyc counts access cycles up to and including the pready cycle.
  task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cyc);
    @(negedge pclk);
    psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wdata;
    @(negedge pclk);
    penable = 1; cyc = 1;
    #1;
    while (!pready && cyc < 200) begin
      @(negedge pclk); cyc++; #1;
    end
    chk("pready_seen", {31'b0, pready}, 32'd1);
    rdata = prdata;
    @(negedge pclk);
    psel = 0; penable = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  off;
    logic [31:0] wdata;
    bit          busy;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_mem [1024];
  logic [31:0] rd;
  int          cyc, m_addr, acc0, bad;

  initial begin
    preset_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    mm_busy = 0; mm_done = 0; m_addr = 0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 0;
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_pready", {31'b0, pready}, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 0);
    chk("rst_mm_start", {31'b0, mm_start}, 0);
    preset_n = 1;

    // CSR vectors; every CSR access must complete in its first access cycle.
    vecs.push_back('{1'b0, 5'h04, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 5'h08, 32'h0004_0302, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'h08, 32'h0, 1'b0, 32'h0004_0302});
    vecs.push_back('{1'b1, 5'h08, 32'h00AA_BBCC, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 5'h08, 32'h0, 1'b1, 32'h0004_0302});
    vecs.push_back('{1'b0, 5'h04, 32'h0, 1'b1, 32'h1});
    vecs.push_back('{1'b1, 5'h0C, 32'hFFFF_F123, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'h0C, 32'h0, 1'b0, 32'h123});
    vecs.push_back('{1'b1, 5'h14, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'h14, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'h00, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 5'h1C, 32'h0, 1'b0, 32'h0});
    foreach (vecs[i]) begin
      mm_busy = vecs[i].busy;
      apb_xfer({27'($urandom), vecs[i].off}, vecs[i].wr, vecs[i].wdata, rd, cyc);
      chk($sformatf("vec%0d_cycles", i), cyc, 1);
      if (!vecs[i].wr) chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp);
    end
    mm_busy = 0;
    chk("dim_m", {24'b0, mm_dim_m}, 32'h2);
    chk("dim_n", {24'b0, mm_dim_n}, 32'h3);
    chk("dim_k", {24'b0, mm_dim_k}, 32'h4);

    // START pulse: exactly the cycle after the write edge, suppressed while busy.
    for (int b = 0; b < 2; b++) begin
      mm_busy = b[0];
      @(negedge pclk); psel = 1; penable = 0; paddr = 0; pwrite = 1; pwdata = 1;
      @(negedge pclk); penable = 1; #1;
      chk("start_pre", {31'b0, mm_start}, 0);
      @(negedge pclk); psel = 0; penable = 0; #1;
      chk("start_pulse", {31'b0, mm_start}, (b == 0) ? 1 : 0);
      @(negedge pclk); #1;
      chk("start_post", {31'b0, mm_start}, 0);
    end
    mm_busy = 0;

    // DONE: sticky, W1C loses against a coincident mm_done.
    @(negedge pclk); mm_done = 1;
    @(negedge pclk); mm_done = 0;
    apb_xfer(32'h04, 0, 0, rd, cyc); chk("done_set", rd, 32'h2);
    @(negedge pclk); psel = 1; penable = 0; paddr = 32'h04; pwrite = 1; pwdata = 2;
    @(negedge pclk); penable = 1; mm_done = 1;
    @(negedge pclk); psel = 0; penable = 0; mm_done = 0;
    apb_xfer(32'h04, 0, 0, rd, cyc); chk("done_w1c_collide", rd, 32'h2);
    apb_xfer(32'h04, 1, 2, rd, cyc);
    apb_xfer(32'h04, 0, 0, rd, cyc); chk("done_w1c", rd, 32'h0);

    // DATA write at the top address with a delayed grant: address wraps afterwards.
    apb_xfer(32'h0C, 1, 32'h3FF, rd, cyc);
    gnt_dly = 3; rv_dly = 1;
    apb_xfer(32'h10, 1, 32'hCAFE, rd, cyc);
    chk("wr_cycles", cyc, 6);
    chk("wr_req_hold", req_hold, 4);
    chk("wr_addr", {22'b0, cap_addr}, 32'h3FF);
    chk("wr_wdata", cap_wdata, 32'hCAFE);
    chk("wr_we", {31'b0, cap_we}, 1);
    chk("wr_stable", {31'b0, unstable}, 0);
    exp_mem[1023] = 32'hCAFE;
    apb_xfer(32'h0C, 0, 0, rd, cyc); chk("wr_addr_wrap", rd, 0);

    // DATA read with immediate grant, rvalid two cycles later.
    memarr[0] = 32'h1234; exp_mem[0] = 32'h1234;
    gnt_dly = 0; rv_dly = 2;
    apb_xfer(32'h10, 0, 0, rd, cyc);
    chk("rd_cycles", cyc, 5);
    chk("rd_data", rd, 32'h1234);
    m_addr = 1;

    // Master drops psel mid DATA write: one memory access, address still advances.
    gnt_dly = 2; acc0 = access_cnt;
    @(negedge pclk); psel = 1; penable = 0; paddr = 32'h10; pwrite = 1; pwdata = 32'hBEEF;
    @(negedge pclk); penable = 1;
    @(negedge pclk); psel = 0; penable = 0;
    repeat (8) @(negedge pclk);
    #1;
    chk("drop_accesses", access_cnt - acc0, 1);
    chk("drop_mem", memarr[m_addr], 32'hBEEF);
    exp_mem[m_addr] = 32'hBEEF; m_addr = m_addr + 1;
    apb_xfer(32'h0C, 0, 0, rd, cyc); chk("drop_addr", rd, m_addr);

    // Randomized DATA traffic against the memory model.
    for (int n = 0; n < 60; n++) begin
      int op = $urandom_range(0, 3);
      logic [31:0] d = $urandom;
      gnt_dly = $urandom_range(0, 3); rv_dly = $urandom_range(1, 3);
      case (op)
        0: begin
          apb_xfer(32'h10, 1, d, rd, cyc);
          chk("rnd_wr_cycles", cyc, 3 + gnt_dly);
          exp_mem[m_addr] = d; m_addr = (m_addr + 1) % 1024;
        end
        1: begin
          apb_xfer(32'h10, 0, 0, rd, cyc);
          chk("rnd_rd_cycles", cyc, 4 + gnt_dly + rv_dly - 1);
          chk("rnd_rd_data", rd, exp_mem[m_addr]);
          m_addr = (m_addr + 1) % 1024;
        end
        2: begin
          m_addr = ($urandom_range(0, 1) != 0) ? $urandom_range(1020, 1023) : $urandom_range(0, 8);
          apb_xfer(32'h0C, 1, {$urandom_range(0, 255), 10'(m_addr)}, rd, cyc);
        end
        default: begin
          apb_xfer(32'h0C, 0, 0, rd, cyc);
          chk("rnd_addr", rd, m_addr);
        end
      endcase
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (memarr[i] !== exp_mem[i]) bad++;
    chk("mem_image_mismatches", bad, 0);

    // Reset during REQ drops mem_req immediately and clears the CSRs.
    gnt_dly = 100;
    @(negedge pclk); psel = 1; penable = 0; paddr = 32'h10; pwrite = 0;
    @(negedge pclk); penable = 1;
    @(negedge pclk); #1;
    chk("req_before_rst", {31'b0, mem_req}, 1);
    #1; preset_n = 0; psel = 0; penable = 0; #1;
    chk("req_after_rst", {31'b0, mem_req}, 0);
    chk("dim_after_rst", {mm_dim_k, mm_dim_n, mm_dim_m}, 0);
    @(negedge pclk); preset_n = 1; gnt_dly = 0;
    apb_xfer(32'h0C, 0, 0, rd, cyc); chk("addr_after_rst", rd, 0);
    apb_xfer(32'h08, 0, 0, rd, cyc); chk("dimreg_after_rst", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
